fetch_stage: RTL

- Initiator side of the instruction-memory interface.
- Owns the program counter and drives a word address to the combinational instruction memory every cycle.
- Captures the returned instruction into the IF/ID pipeline register, and handles stalls and branch/jump redirects from the hazard unit and execute stage.
- Sits between the hazard unit / execute stage and the decode stage of the 5-stage RV32I pipeline.

---
 rtl/fetch_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory, fills IF/ID.
// Optional misaligned-redirect capture is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] FLUSH_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ImemA,
  input  logic [31:0] ImemRD,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        MisalignErr,
  output logic [31:0] MisalignPC,
`endif
  output logic        ValidD
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4d_q, pcp4d_d;
  logic        valid_q, valid_d;
  logic [31:0] pcp4f;

  assign pcp4f    = pc_q + 32'd4;
  assign ImemA    = pc_q;
  assign PCF      = pc_q;
  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4d_q;
  assign ValidD   = valid_q;

  // Next PC: redirect beats stall so a taken branch is never lost.
  always_comb begin
    pc_d = pcp4f;
    if (PCSrcE)
      pc_d = {PCTargetE[31:2], 2'b00};
    else if (StallF)
      pc_d = pc_q;
  end

  // IF/ID next value: flush/redirect beats stall.
  always_comb begin
    instr_d = ImemRD;
    pcd_d   = pc_q;
    pcp4d_d = pcp4f;
    valid_d = 1'b1;
    if (FlushD || PCSrcE) begin
      instr_d = FLUSH_INSTR;
      pcd_d   = 32'd0;
      pcp4d_d = 32'd0;
      valid_d = 1'b0;
    end else if (StallD) begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4d_d = pcp4d_q;
      valid_d = valid_q;
    end
  end

  // PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= FLUSH_INSTR;
      pcd_q   <= 32'd0;
      pcp4d_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4d_q <= pcp4d_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        err_q, err_d;
  logic [31:0] mpc_q, mpc_d;
  logic        mis;

  assign mis         = PCSrcE && (PCTargetE[1:0] != 2'b00);
  assign MisalignErr = err_q;
  assign MisalignPC  = mpc_q;

  // Sticky error; only the first misaligned target is recorded.
  always_comb begin
    err_d = err_q | mis;
    mpc_d = mpc_q;
    if (mis && !err_q)
      mpc_d = PCTargetE;
  end

  // Misalign capture registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
      mpc_q <= 32'd0;
    end else begin
      err_q <= err_d;
      mpc_q <= mpc_d;
    end
  end
`else
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^PCTargetE[1:0];
`endif

endmodule
